// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: run/pause/adjust mode, increment commands
// derived from the 1 Hz / 2 Hz strobes, and the per-digit blink mask used while adjusting.
module stopwatch_ctrl #(
  parameter int unsigned BLINK_HALF = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pause_btn,
  input  logic       adj,
  input  logic       sel,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  output logic       sec_inc,
  output logic       min_inc,
  output logic [3:0] blank,
  output logic       running,
  output logic [1:0] mode
);

  localparam int unsigned CntW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    StPause = 2'b00,
    StRun   = 2'b01,
    StAdj   = 2'b10,
    StBad   = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic            run_flag_q, run_flag_d;
  logic            pause_q;
  logic            pause_edge;
  logic [CntW-1:0] blink_cnt_q, blink_cnt_d;
  logic            blink_phase_q, blink_phase_d;
  logic            sec_inc_q, sec_inc_d;
  logic            min_inc_q, min_inc_d;
  logic [3:0]      blank_q, blank_d;
  logic            running_q, running_d;

  // Mode transitions; run_flag remembers the run/pause choice across ADJ.
  always_comb begin
    pause_edge = pause_btn & ~pause_q;
    run_flag_d = run_flag_q ^ pause_edge;
    state_d    = StPause;
    if (state_q == StBad) begin
      state_d = StPause;
    end else if (adj) begin
      state_d = StAdj;
    end else if (run_flag_d) begin
      state_d = StRun;
    end else begin
      state_d = StPause;
    end
  end

  // Increment commands come from the state held before this edge, not the next one.
  always_comb begin
    sec_inc_d = 1'b0;
    min_inc_d = 1'b0;
    unique case (state_q)
      StRun: sec_inc_d = tick_1hz;
      StAdj: begin
        sec_inc_d = tick_2hz & ~sel;
        min_inc_d = tick_2hz & sel;
      end
      default: ;
    endcase
  end

  // Blink divider: cleared on entry to ADJ so the selected digits start visible.
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if ((state_q != StAdj) && (state_d == StAdj)) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if ((state_q == StAdj) && tick_2hz) begin
      if (blink_cnt_q == CntMax) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Registered display and status outputs, aligned with the next state.
  always_comb begin
    blank_d = 4'b0000;
    if (state_d == StAdj) begin
      blank_d = sel ? {blink_phase_d, blink_phase_d, 2'b00}
                    : {2'b00, blink_phase_d, blink_phase_d};
    end
    running_d = (state_d == StRun);
  end

  // State and output registers; pause_q resets high so a held button does not toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StPause;
      run_flag_q    <= 1'b0;
      pause_q       <= 1'b1;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      sec_inc_q     <= 1'b0;
      min_inc_q     <= 1'b0;
      blank_q       <= 4'b0000;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      run_flag_q    <= run_flag_d;
      pause_q       <= pause_btn;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      sec_inc_q     <= sec_inc_d;
      min_inc_q     <= min_inc_d;
      blank_q       <= blank_d;
      running_q     <= running_d;
    end
  end

  assign sec_inc = sec_inc_q;
  assign min_inc = min_inc_q;
  assign blank   = blank_q;
  assign running = running_q;
  assign mode    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios with literal
// expectations, then randomized stimulus against a behavioural model.
module tb_stopwatch_ctrl;

  localparam int unsigned BH = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pause_btn = 1'b0;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       tick_2hz = 1'b0;
  logic       sec_inc;
  logic       min_inc;
  logic [3:0] blank;
  logic       running;
  logic [1:0] mode;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  // Model state: mode as 0 pause / 1 run / 2 adjust
  int m_mode = 0;
  bit m_run = 1'b0;
  bit m_prev_btn = 1'b1;
  int m_ticks = 0;

  // Expected outputs for the current cycle, and for the next one
  logic       e_sec = 1'b0, e_min = 1'b0, e_run = 1'b0;
  logic [3:0] e_blank = 4'b0;
  logic [1:0] e_mode = 2'b0;
  logic       n_sec, n_min, n_run;
  logic [3:0] n_blank;
  logic [1:0] n_mode;

  stopwatch_ctrl #(.BLINK_HALF(BH)) dut (
    .clk      (clk),
    .rst      (rst),
    .pause_btn(pause_btn),
    .adj      (adj),
    .sel      (sel),
    .tick_1hz (tick_1hz),
    .tick_2hz (tick_2hz),
    .sec_inc  (sec_inc),
    .min_inc  (min_inc),
    .blank    (blank),
    .running  (running),
    .mode     (mode)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  // Compute outputs for the next cycle from the rules, given the inputs now applied.
  task automatic model_step();
    bit edge_seen;
    int nxt;
    int phase;
    if (rst) begin
      m_mode = 0; m_run = 1'b0; m_prev_btn = 1'b1; m_ticks = 0;
      n_sec = 1'b0; n_min = 1'b0; n_blank = 4'b0;
    end else begin
      edge_seen  = pause_btn && !m_prev_btn;
      m_prev_btn = pause_btn;
      n_sec = ((m_mode == 1) && tick_1hz) || ((m_mode == 2) && !sel && tick_2hz);
      n_min = (m_mode == 2) && sel && tick_2hz;
      if (edge_seen) m_run = !m_run;
      if ((m_mode == 2) && tick_2hz) m_ticks++;
      if (adj) begin
        if (m_mode != 2) m_ticks = 0;
        nxt = 2;
      end else begin
        nxt = m_run ? 1 : 0;
      end
      phase = (m_ticks / BH) % 2;
      n_blank = 4'b0;
      if (nxt == 2 && phase == 1) n_blank = sel ? 4'b1100 : 4'b0011;
      m_mode = nxt;
    end
    n_mode = 2'(m_mode);
    n_run  = (m_mode == 1);
  endtask

  // One clock: apply inputs, advance model, return shortly after the falling edge.
  task automatic cyc(input bit r, input bit b, input bit a, input bit s,
                     input bit t1, input bit t2);
    rst = r; pause_btn = b; adj = a; sel = s; tick_1hz = t1; tick_2hz = t2;
    model_step();
    @(posedge clk);
    #1;
    e_sec = n_sec; e_min = n_min; e_blank = n_blank; e_mode = n_mode; e_run = n_run;
    chk_en = 1'b1;
    @(negedge clk);
    #1;
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("mode", {2'b0, mode}, {2'b0, e_mode});
      cmp("running", {3'b0, running}, {3'b0, e_run});
      cmp("blank", blank, e_blank);
      cmp("sec_inc", {3'b0, sec_inc}, {3'b0, e_sec});
      cmp("min_inc", {3'b0, min_inc}, {3'b0, e_min});
      cmp("inc_excl", {3'b0, sec_inc & min_inc}, 4'b0);
    end
  end

  initial begin
    bit b, a, s;
    // Reset and idle
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cmp("lit_reset_mode", {2'b0, mode}, 4'd0);
    cmp("lit_reset_blank", blank, 4'b0000);
    cmp("lit_reset_running", {3'b0, running}, 4'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1, 0);
      cmp("lit_pause_no_inc", {3'b0, sec_inc}, 4'd0);
      cyc(0, 0, 0, 0, 0, 0);
    end
    // Press pause -> RUN; held button gives no further toggles
    cyc(0, 1, 0, 0, 0, 0);
    cmp("lit_run_mode", {2'b0, mode}, 4'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0, 1, 0);
      cmp("lit_run_sec", {3'b0, sec_inc}, 4'd1);
      cyc(0, 1, 0, 0, 0, 0);
      cmp("lit_run_sec_off", {3'b0, sec_inc}, 4'd0);
      cmp("lit_run_held", {2'b0, mode}, 4'd1);
    end
    // Pause edge coinciding with tick_1hz
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 0);
    cmp("lit_edge_run_sec", {3'b0, sec_inc}, 4'd1);
    cmp("lit_edge_run_mode", {2'b0, mode}, 4'd0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 0);
    cmp("lit_edge_pause_sec", {3'b0, sec_inc}, 4'd0);
    cmp("lit_edge_pause_mode", {2'b0, mode}, 4'd1);
    cyc(0, 0, 0, 0, 0, 0);
    // Adjust minutes, blink sequence
    cyc(0, 0, 1, 1, 0, 0);
    cmp("lit_adj_mode", {2'b0, mode}, 4'd2);
    cmp("lit_adj_blank0", blank, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 1, 0, 1);
      cmp("lit_adj_min", {3'b0, min_inc}, 4'd1);
      cmp("lit_adj_nosec", {3'b0, sec_inc}, 4'd0);
      cmp("lit_adj_blank", blank, (i % 2 == 0) ? 4'b1100 : 4'b0000);
      cyc(0, 0, 1, 1, 0, 0);
    end
    cyc(0, 0, 1, 0, 0, 0);
    cmp("lit_sel_move", blank, 4'b0011);
    cyc(0, 0, 1, 0, 0, 1);
    cmp("lit_sel_sec", {3'b0, sec_inc}, 4'd1);
    cmp("lit_sel_blank", blank, 4'b0000);
    // Pause pressed inside ADJ
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cmp("lit_adj_exit_pause", {2'b0, mode}, 4'd0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cmp("lit_adj_exit_run", {2'b0, mode}, 4'd1);
    // Reset in ADJ with phase 1, button held through reset
    cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 0, 1, 1, 0, 1);
    cmp("lit_pre_rst_blank", blank, 4'b1100);
    cyc(1, 1, 1, 1, 0, 1);
    cmp("lit_rst_mode", {2'b0, mode}, 4'd0);
    cmp("lit_rst_blank", blank, 4'b0000);
    cmp("lit_rst_min", {3'b0, min_inc}, 4'd0);
    cyc(0, 1, 0, 0, 0, 0);
    cmp("lit_held_no_toggle", {2'b0, mode}, 4'd0);
    cyc(0, 0, 0, 0, 0, 0);
    // Randomized run
    b = 1'b0; a = 1'b0; s = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) b = ~b;
      if ($urandom_range(23) == 0) a = ~a;
      if ($urandom_range(9) == 0) s = ~s;
      cyc(($urandom_range(199) == 0), b, a, s,
          ($urandom_range(5) == 0), ($urandom_range(3) == 0));
    end
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
